// File: rtl/seq_detector_prog.sv
// seq_detector_prog: run-time programmable serial bit-pattern detector.
// Flags each occurrence of a configured marker on a qualified 1-bit stream.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   x           serial data bit
//   x_valid     qualifies x; unqualified bits are ignored
//   cfg_load    strobe: latch cfg_* on this edge (if cfg_len is legal)
//   cfg_pattern pattern, bit [len-1] received first, bit [0] last
//   cfg_len     pattern length, legal range 1..MAX_LEN
//   cfg_overlap 1 = overlapping detection
//   cfg_mealy   1 = Mealy output, 0 = Moore (one cycle later)
//   cnt_clr     synchronous clear of match_cnt
//   z           match pulse
//   match_cnt   saturating match counter
//   cfg_err     one-cycle pulse after a rejected cfg_load
module seq_detector_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0010_1111),
    parameter logic [LEN_W-1:0]   DEF_LEN     = LEN_W'(6),
    parameter logic               DEF_OVERLAP = 1'b0,
    parameter logic               DEF_MEALY   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               x_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cfg_mealy,
    input  logic               cnt_clr,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W:0]   ONE_X   = (LEN_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // active configuration
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;
    logic               mealy;

    // stream state
    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   fill;
    logic               z_q;

    // combinational helpers
    logic               len_ok;
    logic               load_ok;
    logic               load_bad;
    logic               take;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_p1;
    logic               full;
    logic               hit;
    logic               match;
    logic [LEN_W-1:0]   fill_nxt;

    // ---------------------------------------------------------------
    // Config strobe qualification
    // ---------------------------------------------------------------
    always_comb begin
        len_ok   = (cfg_len != '0) && (cfg_len <= LEN_MAX);
        load_ok  = cfg_load && len_ok;
        load_bad = cfg_load && !len_ok;
    end

    // An accepted reload flushes the history, so a bit arriving in
    // the same cycle is dropped rather than judged against either
    // the old or the new pattern.
    assign take = x_valid && !load_ok;

    // ---------------------------------------------------------------
    // Window compare
    // ---------------------------------------------------------------
    // The whole history plus the new bit forms a MAX_LEN window;
    // only the low len bits take part in the compare.
    assign window = {hist, x};

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    // fill counts bits already in hist; a match needs len-1 of them
    always_comb begin
        fill_p1 = {1'b0, fill} + ONE_X;
        full    = (fill_p1 >= {1'b0, len});
        hit     = full && ((window & mask) == (pat & mask));
        match   = take && hit;
    end

    // Non-overlap mode restarts the fill so the next match needs
    // len fresh bits; otherwise saturate at MAX_LEN.
    always_comb begin
        fill_nxt = fill;
        if (match && !ovl) begin
            fill_nxt = '0;
        end else if (fill != LEN_MAX) begin
            fill_nxt = fill + LEN_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Configuration register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pat   <= DEF_PATTERN;
            len   <= DEF_LEN;
            ovl   <= DEF_OVERLAP;
            mealy <= DEF_MEALY;
        end else if (load_ok) begin
            pat   <= cfg_pattern;
            len   <= cfg_len;
            ovl   <= cfg_overlap;
            mealy <= cfg_mealy;
        end
    end

    // ---------------------------------------------------------------
    // History and fill
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
        end else if (load_ok) begin
            hist <= '0;
            fill <= '0;
        end else if (take) begin
            hist <= window[MAX_LEN-2:0];
            fill <= fill_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Moore output register and config error pulse
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            z_q     <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            z_q     <= match;
            cfg_err <= load_bad;
        end
    end

    // ---------------------------------------------------------------
    // Saturating match counter; clear wins over increment
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (match && (match_cnt != CNT_MAX)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Output select; held low while reset is asserted
    // ---------------------------------------------------------------
    always_comb begin
        z = 1'b0;
        if (!rst) begin
            z = mealy ? match : z_q;
        end
    end

endmodule
